// File: rtl/iter_divider.sv
// Multicycle signed 32-bit restoring divider producing one quotient bit per clock.
// Define ITER_DIVIDER_REM_EN to add the signed remainder output rem_out.
module iter_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out,
    output logic             exception,
    output logic             ready,
    output logic             busy
`ifdef ITER_DIVIDER_REM_EN
    ,
    output logic [WIDTH-1:0] rem_out
`endif
);

    localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             sign_q;
    logic             ready_q;

    logic             accept;
    logic             div_zero;
    logic             overflow;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             trial_ok;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

`ifdef ITER_DIVIDER_REM_EN
    logic             sign_r;
`endif

    // Operand decode plus one restoring step on the {rem,quo} pair.
    always_comb begin
        accept   = start && ((state == IDLE) || (state == DONE));
        div_zero = (in2 == '0);
        overflow = (in1 == MIN_VAL) && (in2 == '1);
        mag1     = in1[WIDTH-1] ? -in1 : in1;
        mag2     = in2[WIDTH-1] ? -in2 : in2;
        shifted  = {rem, quo[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_mag};
        trial_ok = ~trial[WIDTH];
        rem_step = trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_step = {quo[WIDTH-2:0], trial_ok};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (div_zero || overflow) ? DONE : RUN;
                end
            end
            RUN: begin
                if (count == LAST_STEP) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = DONE;
            end
            DONE: begin
                if (accept) begin
                    state_next = (div_zero || overflow) ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Exceptional operands load the result at the accept edge; normal ones at FIX.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count     <= '0;
            dvs_mag   <= '0;
            quo       <= '0;
            rem       <= '0;
            sign_q    <= 1'b0;
            out       <= '0;
            exception <= 1'b0;
`ifdef ITER_DIVIDER_REM_EN
            sign_r    <= 1'b0;
            rem_out   <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        count   <= '0;
                        dvs_mag <= mag2;
                        quo     <= mag1;
                        rem     <= '0;
                        sign_q  <= in1[WIDTH-1] ^ in2[WIDTH-1];
`ifdef ITER_DIVIDER_REM_EN
                        sign_r  <= in1[WIDTH-1];
`endif
                        if (div_zero) begin
                            out       <= '0;
                            exception <= 1'b1;
`ifdef ITER_DIVIDER_REM_EN
                            rem_out   <= in1;
`endif
                        end else if (overflow) begin
                            out       <= MIN_VAL;
                            exception <= 1'b1;
`ifdef ITER_DIVIDER_REM_EN
                            rem_out   <= '0;
`endif
                        end
                    end
                end
                RUN: begin
                    rem <= rem_step;
                    quo <= quo_step;
                    if (count != CNT_MAX) begin
                        count <= count + 1'b1;
                    end
                end
                FIX: begin
                    out       <= sign_q ? -quo : quo;
                    exception <= 1'b0;
`ifdef ITER_DIVIDER_REM_EN
                    rem_out   <= sign_r ? -rem : rem;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    // The completion pulse trails the DONE state by one clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= (state == DONE);
        end
    end

    assign ready = ready_q;
    assign busy  = ((state == RUN) || (state == FIX)) && !ready_q;

    ready_busy_exclusive: assert property (@(posedge clock) disable iff (!reset_n) !(ready && busy));

endmodule

// File: tb/tb_iter_divider.sv
// Randomized self-checking bench for iter_divider against a plain-arithmetic division model.
module tb_iter_divider;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic [31:0] in1     = '0;
    logic [31:0] in2     = '0;
    logic [31:0] out;
    logic        exception;
    logic        ready;
    logic        busy;
`ifdef ITER_DIVIDER_REM_EN
    logic [31:0] rem_out;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    iter_divider dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .in1       (in1),
        .in2       (in2),
        .out       (out),
        .exception (exception),
        .ready     (ready),
        .busy      (busy)
`ifdef ITER_DIVIDER_REM_EN
        ,
        .rem_out   (rem_out)
`endif
    );

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Signed division truncating toward zero, with the two exceptional operand pairs.
    function automatic void refDiv(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r,
                                   output logic e);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'd0;
            r = a;
            e = 1'b1;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            q = 32'h80000000;
            r = 32'd0;
            e = 1'b1;
        end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
            e = 1'b0;
        end
    endfunction

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit now,
                                 output int lat, output bit busy_seen, output bit overlap);
        if (!now) @(negedge clock);
        in1   = a;
        in2   = b;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start     = 1'b0;
        in1       = $urandom;
        in2       = $urandom;
        lat       = 0;
        busy_seen = 1'b0;
        overlap   = 1'b0;
        while (!ready && lat < 60) begin
            if (busy) busy_seen = 1'b1;
            @(posedge clock);
            lat++;
            @(negedge clock);
            if (ready && busy) overlap = 1'b1;
        end
    endtask

    task automatic runCase(input string name, input logic [31:0] a, input logic [31:0] b, input bit now);
        logic [31:0] eq;
        logic [31:0] er;
        logic        ee;
        int          lat;
        bit          bs;
        bit          ov;
        refDiv(a, b, eq, er, ee);
        applyStimulus(a, b, now, lat, bs, ov);
        checkOutput({name, ".lat"}, 32'(lat), ee ? 32'd1 : 32'd34);
        checkOutput({name, ".out"}, out, eq);
        checkOutput({name, ".exc"}, {31'b0, exception}, {31'b0, ee});
        checkOutput({name, ".overlap"}, {31'b0, ov}, 32'd0);
        if (ee) checkOutput({name, ".busy_seen"}, {31'b0, bs}, 32'd0);
`ifdef ITER_DIVIDER_REM_EN
        checkOutput({name, ".rem"}, rem_out, er);
`endif
    endtask

    initial begin
        bit ready_seen;
        logic [31:0] ra;
        logic [31:0] rb;

        repeat (3) @(negedge clock);
        checkOutput("reset.out", out, 32'd0);
        checkOutput("reset.exc", {31'b0, exception}, 32'd0);
        checkOutput("reset.ready", {31'b0, ready}, 32'd0);
        checkOutput("reset.busy", {31'b0, busy}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        runCase("pos", 32'd100, 32'd7, 1'b0);
        @(negedge clock);
        checkOutput("pos.pulse", {31'b0, ready}, 32'd0);
        checkOutput("pos.hold", out, 32'd14);

        runCase("neg", 32'hFFFFFF9C, 32'd7, 1'b0);
        runCase("divzero", 32'd5, 32'd0, 1'b0);
        runCase("ovf", 32'h80000000, 32'hFFFFFFFF, 1'b0);

        // Abandon a division with reset; a start while busy must be ignored.
        @(negedge clock);
        in1   = 32'd1000;
        in2   = 32'd10;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start      = 1'b0;
        ready_seen = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 10) begin
                in1   = 32'd9;
                in2   = 32'd3;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clock);
            @(negedge clock);
            if (ready) ready_seen = 1'b1;
        end
        checkOutput("abort.busy", {31'b0, busy}, 32'd1);
        checkOutput("abort.noready", {31'b0, ready_seen}, 32'd0);
        checkOutput("abort.out_held", out, 32'h80000000);
        reset_n = 1'b0;
        #1;
        checkOutput("abort.out", out, 32'd0);
        checkOutput("abort.exc", {31'b0, exception}, 32'd0);
        checkOutput("abort.ready", {31'b0, ready}, 32'd0);
        checkOutput("abort.busyrst", {31'b0, busy}, 32'd0);
`ifdef ITER_DIVIDER_REM_EN
        checkOutput("abort.rem", rem_out, 32'd0);
`endif
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        runCase("after_reset", 32'd9, 32'd3, 1'b0);

        runCase("b2b_first", 32'd50, 32'd5, 1'b0);
        runCase("b2b", 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = -32'($urandom_range(1, 15));
                3:       begin ra = 32'h80000000; rb = ($urandom_range(0, 1) == 0) ? 32'hFFFFFFFF : 32'd3; end
                default: rb = $urandom;
            endcase
            runCase($sformatf("rand%0d", i), ra, rb, ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
